// File: rtl/spd_avg_mon.sv
// -----------------------------------------------------------------------------
// spd_avg_mon
// Purpose : Windowed averaging speed monitor for the left/right motor speed
//           commands coming out of the balance controller. Produces per-window
//           averages, a window-to-window trend indication and a sustained
//           left/right imbalance flag.
//
// Ports   :
//   clk       in   1   system clock
//   rst       in   1   asynchronous active-high reset
//   en        in   1   monitor enable; low = idle, window and counters cleared
//   vld       in   1   sample strobe, lft_spd/rght_spd valid this cycle
//   lft_spd   in   12  signed left speed sample
//   rght_spd  in   12  signed right speed sample
//   avg_lft   out  12  signed average of last completed left window
//   avg_rght  out  12  signed average of last completed right window
//   avg_vld   out  1   one-cycle pulse: new averages/trend valid
//   trend_up  out  1   both averages rose versus the previous window
//   trend_dn  out  1   both averages fell versus the previous window
//   mismatch  out  1   sustained left/right imbalance
//   win_cnt   out  8   completed windows since enable, saturating at 255
// -----------------------------------------------------------------------------
module spd_avg_mon #(
  parameter int SMPL_LOG2 = 3,
  parameter int TOL       = 10,
  parameter int MIS_CNT   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               vld,
  input  logic signed [11:0] lft_spd,
  input  logic signed [11:0] rght_spd,
  output logic signed [11:0] avg_lft,
  output logic signed [11:0] avg_rght,
  output logic               avg_vld,
  output logic               trend_up,
  output logic               trend_dn,
  output logic               mismatch,
  output logic [7:0]         win_cnt
);

  // Accumulator width: N samples of 12 bits never overflow 12+log2(N) bits.
  localparam int AW = 12 + SMPL_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_REPORT
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SMPL_LOG2-1:0] r_cnt;
  logic [7:0]           r_imb;
  logic                 r_mis;
  logic                 r_pv;
  logic [7:0]           r_win;
  logic                 r_tu;
  logic                 r_td;

  // A sample is accepted in ACCUM and in REPORT (the REPORT-cycle sample
  // opens the next window). en low always wins over vld.
  logic w_take;
  logic w_last;

  assign w_take = en && vld && (r_state != S_IDLE);
  // The count wraps to zero on its own after the Nth sample.
  assign w_last = w_take && (r_cnt == {SMPL_LOG2{1'b1}});

  // ---------------------------------------------------------------------------
  // Per-channel datapath: index 0 = left, index 1 = right
  // ---------------------------------------------------------------------------
  logic signed [11:0]   w_smp  [2];
  logic signed [AW-1:0] w_ext  [2];
  logic signed [AW-1:0] w_sum  [2];
  logic signed [AW-1:0] w_shr  [2];
  logic signed [11:0]   w_avg  [2];
  logic signed [AW-1:0] r_acc  [2];
  logic signed [11:0]   r_avg  [2];
  logic signed [11:0]   r_prev [2];
  logic [1:0]           w_gt;
  logic [1:0]           w_lt;

  assign w_smp[0] = lft_spd;
  assign w_smp[1] = rght_spd;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      assign w_ext[gi] = {{SMPL_LOG2{w_smp[gi][11]}}, w_smp[gi]};
      // Sum including the current sample, so the Nth sample's average is
      // ready to register on the same edge it is accepted.
      assign w_sum[gi] = r_acc[gi] + w_ext[gi];
      // Arithmetic shift floors toward -inf.
      assign w_shr[gi] = w_sum[gi] >>> SMPL_LOG2;
      assign w_avg[gi] = w_shr[gi][11:0];
      assign w_gt[gi]  = (w_avg[gi] > r_prev[gi]);
      assign w_lt[gi]  = (w_avg[gi] < r_prev[gi]);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_acc[gi]  <= '0;
          r_avg[gi]  <= '0;
          r_prev[gi] <= '0;
        end else if (!en) begin
          // Averages and previous-window values hold while idle.
          r_acc[gi] <= '0;
        end else if (w_take) begin
          if (w_last) begin
            r_acc[gi]  <= '0;
            r_avg[gi]  <= w_avg[gi];
            r_prev[gi] <= w_avg[gi];
          end else begin
            r_acc[gi] <= w_sum[gi];
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Imbalance detection: |l - r| at 13 bits so the extremes cannot wrap
  // ---------------------------------------------------------------------------
  logic signed [12:0] w_dsub;
  logic [12:0]        w_diff;
  logic [7:0]         w_imb_next;

  assign w_dsub = {lft_spd[11], lft_spd} - {rght_spd[11], rght_spd};
  assign w_diff = w_dsub[12] ? 13'(-w_dsub) : 13'(w_dsub);

  always_comb begin
    w_imb_next = r_imb;
    if (w_diff > 13'(TOL)) begin
      if (r_imb != 8'(MIS_CNT)) begin
        w_imb_next = r_imb + 8'd1;
      end
    end else begin
      w_imb_next = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (!en) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_state_next = S_ACCUM;
        S_ACCUM,
        S_REPORT: w_state_next = w_last ? S_REPORT : S_ACCUM;
        default:  w_state_next = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control / status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_imb <= '0;
      r_mis <= 1'b0;
      r_pv  <= 1'b0;
      r_win <= '0;
      r_tu  <= 1'b0;
      r_td  <= 1'b0;
    end else if (!en) begin
      // Trend flags hold while idle; the next first window clears them
      // because prev_valid is dropped here.
      r_cnt <= '0;
      r_imb <= '0;
      r_mis <= 1'b0;
      r_pv  <= 1'b0;
      r_win <= '0;
    end else if (w_take) begin
      r_cnt <= r_cnt + 1'b1;
      r_imb <= w_imb_next;
      r_mis <= (w_imb_next == 8'(MIS_CNT));
      if (w_last) begin
        r_pv <= 1'b1;
        r_tu <= r_pv && (&w_gt);
        r_td <= r_pv && (&w_lt);
        if (r_win != 8'hFF) begin
          r_win <= r_win + 8'd1;
        end
      end
    end
  end

  // Averages are registered on the Nth-sample edge, so they are already on
  // the outputs during the REPORT cycle.
  assign avg_lft  = r_avg[0];
  assign avg_rght = r_avg[1];
  assign avg_vld  = (r_state == S_REPORT);
  assign trend_up = r_tu;
  assign trend_dn = r_td;
  assign mismatch = r_mis;
  assign win_cnt  = r_win;

endmodule

// File: tb/tb_spd_avg_mon.sv
// -----------------------------------------------------------------------------
// tb_spd_avg_mon
// Purpose : Directed self-checking bench for spd_avg_mon (default parameters:
//           N = 8, TOL = 10, MIS_CNT = 4). Expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_spd_avg_mon;

  logic               clk;
  logic               rst;
  logic               en;
  logic               vld;
  logic signed [11:0] lft_spd;
  logic signed [11:0] rght_spd;
  logic signed [11:0] avg_lft;
  logic signed [11:0] avg_rght;
  logic               avg_vld;
  logic               trend_up;
  logic               trend_dn;
  logic               mismatch;
  logic [7:0]         win_cnt;

  int n_tests;
  int n_fail;

  spd_avg_mon dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .vld      (vld),
    .lft_spd  (lft_spd),
    .rght_spd (rght_spd),
    .avg_lft  (avg_lft),
    .avg_rght (avg_rght),
    .avg_vld  (avg_vld),
    .trend_up (trend_up),
    .trend_dn (trend_dn),
    .mismatch (mismatch),
    .win_cnt  (win_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted-sample transaction; returns #1 after the sampling edge.
  task automatic send1(input logic signed [11:0] l, input logic signed [11:0] r);
    vld      = 1'b1;
    lft_spd  = l;
    rght_spd = r;
    tick();
    vld = 1'b0;
  endtask

  // Full window back-to-back: first sample (l0,r0), then 7 samples (ln,rn).
  task automatic send_win(input logic signed [11:0] l0, input logic signed [11:0] r0,
                          input logic signed [11:0] ln, input logic signed [11:0] rn);
    send1(l0, r0);
    chk_eq("win_novld", int'(avg_vld), 0);
    for (int i = 1; i < 8; i++) begin
      send1(ln, rn);
      if (i < 7) chk_eq("win_novld", int'(avg_vld), 0);
    end
    chk_eq("win_vld", int'(avg_vld), 1);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    en       = 1'b0;
    vld      = 1'b0;
    lft_spd  = '0;
    rght_spd = '0;

    // ---------------- reset / idle ----------------
    tick();
    tick();
    chk_eq("rst_avg_lft", int'(avg_lft), 0);
    chk_eq("rst_avg_vld", int'(avg_vld), 0);
    chk_eq("rst_win_cnt", int'(win_cnt), 0);
    chk_eq("rst_mismatch", int'(mismatch), 0);
    chk_eq("rst_trend_up", int'(trend_up), 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vld      = (i % 2 == 0);
      lft_spd  = 12'sd500;
      rght_spd = -12'sd500;
      tick();
      chk_eq("idle_avg_vld", int'(avg_vld), 0);
    end
    vld = 1'b0;
    chk_eq("idle_mismatch", int'(mismatch), 0);
    chk_eq("idle_win_cnt", int'(win_cnt), 0);

    // ---------------- constant window ----------------
    en = 1'b1;
    tick();
    send_win(12'sd100, 12'sd100, 12'sd100, 12'sd100);
    chk_eq("w1_avg_lft", int'(avg_lft), 100);
    chk_eq("w1_avg_rght", int'(avg_rght), 100);
    chk_eq("w1_trend_up", int'(trend_up), 0);
    chk_eq("w1_trend_dn", int'(trend_dn), 0);
    chk_eq("w1_win_cnt", int'(win_cnt), 1);
    tick();
    chk_eq("w1_pulse_once", int'(avg_vld), 0);

    // ---------------- trend up then down ----------------
    send_win(12'sd200, 12'sd200, 12'sd200, 12'sd200);
    chk_eq("w2_avg_lft", int'(avg_lft), 200);
    chk_eq("w2_trend_up", int'(trend_up), 1);
    chk_eq("w2_trend_dn", int'(trend_dn), 0);
    chk_eq("w2_win_cnt", int'(win_cnt), 2);
    tick();
    send_win(-12'sd50, -12'sd50, -12'sd50, -12'sd50);
    chk_eq("w3_avg_lft_hex", int'(unsigned'(avg_lft)), 'hFCE);
    chk_eq("w3_avg_rght", int'(avg_rght), -50);
    chk_eq("w3_trend_up", int'(trend_up), 0);
    chk_eq("w3_trend_dn", int'(trend_dn), 1);
    tick();
    chk_eq("w3_trend_hold", int'(trend_dn), 1);

    // ---------------- negative floor and back-to-back ----------------
    send_win(-12'sd1, -12'sd1, 12'sd0, 12'sd0);
    chk_eq("w4_avg_lft", int'(avg_lft), -1);
    chk_eq("w4_avg_rght", int'(avg_rght), -1);
    chk_eq("w4_trend_up", int'(trend_up), 1);
    // First sample of the next window lands in the REPORT cycle.
    send_win(12'sd80, 12'sd80, 12'sd0, 12'sd0);
    chk_eq("w5_avg_lft", int'(avg_lft), 10);
    chk_eq("w5_avg_rght", int'(avg_rght), 10);
    chk_eq("w5_win_cnt", int'(win_cnt), 5);
    tick();

    // ---------------- idle holds averages, clears count ----------------
    en = 1'b0;
    tick();
    tick();
    chk_eq("dis_avg_hold", int'(avg_lft), 10);
    chk_eq("dis_win_cnt", int'(win_cnt), 0);

    // ---------------- mismatch ----------------
    en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      send1(12'sd500, 12'sd480);
      chk_eq("mis_below_cnt", int'(mismatch), 0);
    end
    send1(12'sd500, 12'sd480);
    chk_eq("mis_4th", int'(mismatch), 1);
    send1(12'sd500, 12'sd495);
    chk_eq("mis_in_tol", int'(mismatch), 0);
    for (int i = 0; i < 3; i++) begin
      send1(-12'sd2048, 12'sd2047);
      chk_eq("mis_ext_below", int'(mismatch), 0);
    end
    send1(-12'sd2048, 12'sd2047);
    chk_eq("mis_ext_4th", int'(mismatch), 1);
    send1(12'sd500, 12'sd490);
    chk_eq("mis_diff_eq_tol", int'(mismatch), 0);
    tick();

    // ---------------- abort mid-window ----------------
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) send1(12'sd1000, 12'sd1000);
    // en falls together with a vld: the sample must be discarded.
    en = 1'b0;
    send1(12'sd1000, 12'sd1000);
    chk_eq("abort_win_cnt", int'(win_cnt), 0);
    chk_eq("abort_avg_vld", int'(avg_vld), 0);
    en = 1'b1;
    tick();
    send_win(12'sd10, 12'sd10, 12'sd10, 12'sd10);
    chk_eq("abort_avg_lft", int'(avg_lft), 10);
    chk_eq("abort_win_cnt1", int'(win_cnt), 1);
    chk_eq("abort_trend_up", int'(trend_up), 0);
    chk_eq("abort_trend_dn", int'(trend_dn), 0);
    tick();

    // ---------------- asynchronous reset mid-window ----------------
    for (int i = 0; i < 3; i++) send1(12'sd40, 12'sd40);
    #2 rst = 1'b1;
    #1;
    chk_eq("arst_avg_lft", int'(avg_lft), 0);
    chk_eq("arst_win_cnt", int'(win_cnt), 0);
    chk_eq("arst_avg_vld", int'(avg_vld), 0);
    rst = 1'b0;
    tick();
    send_win(12'sd40, 12'sd40, 12'sd40, 12'sd40);
    chk_eq("arst_w_avg", int'(avg_lft), 40);
    chk_eq("arst_w_cnt", int'(win_cnt), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
